// File: rtl/sha3_msg_loader.sv
// Byte-stream front end for the sha3 request port: packs N/8 bytes big-endian
// into md_in, then holds the word on a req_valid/req_ready handshake.
//
// Handshakes:
// - A byte moves when s_valid && s_ready at a rising edge.
// - A request moves when req_valid && req_ready at a rising edge.
// - s_ready and req_valid depend only on the state register, never on inputs.
// - Once raised, req_valid stays high with md_in frozen until the request moves.
module sha3_msg_loader #(
    parameter  int N  = 344,
    localparam int NB = N / 8,
    localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [N-1:0] md_in,
    output logic         req_valid,
    input  logic         req_ready,
    output logic         err_len,
    output logic [15:0]  msg_count
);

    if ((N % 8) != 0 || N < 8) begin : g_bad_n
        $error("sha3_msg_loader: N must be a multiple of 8 and at least 8");
    end

    typedef enum logic [0:0] {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  md_q, md_d;
    logic          err_len_q, err_len_d;
    logic [15:0]   msg_count_q, msg_count_d;

    logic          at_last_idx;
    logic          byte_fire;
    logic          req_fire;

    assign at_last_idx = (idx_q == LAST_IDX);
    assign byte_fire   = s_valid && (state_q == FILL);
    assign req_fire    = req_ready && (state_q == SEND);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        md_d        = md_q;
        err_len_d   = 1'b0;
        msg_count_d = msg_count_q;

        if (byte_fire) begin
            if (s_last != at_last_idx) begin
                // Too short or too long: the byte is dropped and the next one
                // starts a fresh message at index 0.
                err_len_d = 1'b1;
                idx_d     = '0;
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (idx_q == IW'(b)) begin
                        md_d[N-1-8*b -: 8] = s_data;
                    end
                end
                if (s_last) begin
                    idx_d   = '0;
                    state_d = SEND;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end

        if (req_fire) begin
            state_d     = FILL;
            msg_count_d = msg_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FILL;
            idx_q       <= '0;
            md_q        <= '0;
            err_len_q   <= 1'b0;
            msg_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            md_q        <= md_d;
            err_len_q   <= err_len_d;
            msg_count_q <= msg_count_d;
        end
    end

    assign s_ready   = (state_q == FILL);
    assign req_valid = (state_q == SEND);
    assign md_in     = md_q;
    assign err_len   = err_len_q;
    assign msg_count = msg_count_q;

endmodule

// File: tb/tb_sha3_msg_loader.sv
// Directed bench for sha3_msg_loader: fox message, backpressure, short and long
// messages, back-to-back traffic and asynchronous reset mid-message.
module tb_sha3_msg_loader;

    localparam int N  = 344;
    localparam int NB = N / 8;

    logic         clk;
    logic         rstn;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [N-1:0] md_in;
    logic         req_valid;
    logic         req_ready;
    logic         err_len;
    logic [15:0]  msg_count;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    int handshakes = 0;

    logic [N-1:0] fox;
    logic [N-1:0] msg2;

    sha3_msg_loader #(.N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .md_in     (md_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .err_len   (err_len),
        .msg_count (msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (err_len) err_pulses++;
        if (req_valid && req_ready) handshakes++;
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams nbytes of m, one per cycle; last_at is the byte carrying s_last (-1: none).
    task automatic drive_msg(input logic [N-1:0] m, input int nbytes, input int last_at);
        for (int i = 0; i < nbytes; i++) begin
            s_valid = 1'b1;
            s_data  = m[N-1-8*i -: 8];
            s_last  = (i == last_at);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    initial begin
        int idle;
        int cyc;
        int byte_i;
        int msg_k;
        logic [N-1:0] cur;

        fox = 344'h54686520717569636b2062726f776e20666f78206a756d7073206f76657220746865206c617a7920646f67;
        msg2 = '0;
        for (int i = 0; i < NB; i++) msg2[N-1-8*i -: 8] = 8'((i * 7 + 3) & 8'hFF);

        rstn = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; req_ready = 1'b1;
        #2;
        check("rst_s_ready",   N'(s_ready),   N'(1));
        check("rst_req_valid", N'(req_valid), N'(0));
        check("rst_md_in",     md_in,         '0);
        check("rst_err_len",   N'(err_len),   N'(0));
        check("rst_msg_count", N'(msg_count), N'(0));
        #10 rstn = 1'b1;
        tick();

        // Fox message with req_ready held high.
        drive_msg(fox, NB, NB - 1);
        check("fox_req_valid", N'(req_valid), N'(1));
        check("fox_md_in",     md_in,         fox);
        check("fox_s_ready",   N'(s_ready),   N'(0));
        check("fox_count_pre", N'(msg_count), N'(0));
        tick();
        check("fox_req_drop",  N'(req_valid), N'(0));
        check("fox_s_ready2",  N'(s_ready),   N'(1));
        check("fox_count",     N'(msg_count), N'(1));
        check("fox_hs",        N'(handshakes), N'(1));

        // Backpressure: junk bytes offered during SEND must be ignored.
        req_ready = 1'b0;
        drive_msg(fox, NB, NB - 1);
        s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_req_valid", N'(req_valid), N'(1));
            check("bp_md_in",     md_in,         fox);
            check("bp_s_ready",   N'(s_ready),   N'(0));
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        req_ready = 1'b1;
        check("bp_still_valid", N'(req_valid), N'(1));
        check("bp_count_pre",   N'(msg_count), N'(1));
        tick();
        check("bp_req_drop",  N'(req_valid), N'(0));
        check("bp_count",     N'(msg_count), N'(2));

        // Short message, then a correct one starting in the err_len cycle.
        drive_msg(msg2, 11, 10);
        check("short_err",       N'(err_len),   N'(1));
        check("short_no_req",    N'(req_valid), N'(0));
        check("short_s_ready",   N'(s_ready),   N'(1));
        drive_msg(fox, NB, NB - 1);
        check("short_err_once",  N'(err_pulses), N'(1));
        check("short_next_req",  N'(req_valid), N'(1));
        check("short_next_md",   md_in,         fox);
        tick();
        check("short_count",     N'(msg_count), N'(3));

        // Long message: no s_last on the final byte.
        drive_msg(fox, NB, -1);
        check("long_err",       N'(err_len),   N'(1));
        check("long_no_req",    N'(req_valid), N'(0));
        check("long_count",     N'(msg_count), N'(3));
        drive_msg(msg2, NB, NB - 1);
        check("long_err_once",  N'(err_pulses), N'(2));
        check("long_next_req",  N'(req_valid), N'(1));
        check("long_next_md",   md_in,         msg2);
        tick();
        check("long_hs",        N'(handshakes), N'(4));

        // Back-to-back: s_valid never drops; one idle cycle between messages.
        idle = 0; byte_i = 0; msg_k = 0; cyc = 0;
        while (msg_k < 2 && cyc < 200) begin
            cur = (msg_k == 0) ? fox : msg2;
            s_valid = 1'b1;
            s_data  = cur[N-1-8*byte_i -: 8];
            s_last  = (byte_i == NB - 1);
            if (s_ready) begin
                byte_i++;
                if (byte_i == NB) begin
                    byte_i = 0;
                    msg_k++;
                end
            end else begin
                idle++;
                check("b2b_idle_md", md_in, fox);
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("b2b_in_budget", N'(cyc < 200), N'(1));
        check("b2b_idle",      N'(idle),      N'(1));
        check("b2b_req",       N'(req_valid), N'(1));
        check("b2b_md",        md_in,         msg2);
        tick();
        check("b2b_count",     N'(msg_count), N'(6));
        check("b2b_hs",        N'(handshakes), N'(6));

        // Asynchronous reset after byte 20.
        drive_msg(msg2, 21, -1);
        rstn = 1'b0;
        #1;
        check("arst_md_in",     md_in,         '0);
        check("arst_s_ready",   N'(s_ready),   N'(1));
        check("arst_req_valid", N'(req_valid), N'(0));
        check("arst_count",     N'(msg_count), N'(0));
        #3 rstn = 1'b1;
        tick();
        drive_msg(fox, NB, NB - 1);
        check("arst_next_req",  N'(req_valid), N'(1));
        check("arst_next_md",   md_in,         fox);
        tick();
        check("arst_next_cnt",  N'(msg_count), N'(1));
        check("err_total",      N'(err_pulses), N'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
